// File: rtl/nwc_pkg.sv
// Shared constants and types for the coefficient-memory unload path.
// Modules take their own parameters so narrow corner builds stay possible.
package nwc_pkg;

    localparam int D_WIDTH = 32;
    localparam int BN      = 16;
    localparam int MA      = 64;
    localparam int AW      = (MA > 1) ? $clog2(MA) : 1;
    localparam int IW      = $clog2(BN * MA);

    typedef logic [D_WIDTH-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } unload_state_e;

endpackage

// File: rtl/mem_unload_streamer_if.sv
// Memory read port plus output stream of the unload engine.
// The engine takes the master side; memory and host sit on the slave side.
interface mem_unload_streamer_if #(
    parameter int D_WIDTH = nwc_pkg::D_WIDTH,
    parameter int BN      = nwc_pkg::BN,
    parameter int AW      = nwc_pkg::AW,
    parameter int IW      = nwc_pkg::IW
);

    logic                  start;
    logic                  mem_rd_en;
    logic [AW-1:0]         mem_rd_addr;
    logic [BN*D_WIDTH-1:0] mem_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [D_WIDTH-1:0]    out_data;
    logic [IW-1:0]         out_index;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, mem_rd_data, out_ready,
        output mem_rd_en, mem_rd_addr, out_valid, out_data, out_index,
               out_last, busy, done
    );

    modport slave (
        output start, mem_rd_data, out_ready,
        input  mem_rd_en, mem_rd_addr, out_valid, out_data, out_index,
               out_last, busy, done
    );

endinterface

// File: rtl/row_pingpong_buf.sv
// Two row slots filled alternately from the memory read port and drained one
// column per handshake; predicts whether the next write slot is free at capture.
module row_pingpong_buf #(
    parameter int D_WIDTH = 32,
    parameter int BN      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  issue_i,
    input  logic [BN*D_WIDTH-1:0] rd_data_i,
    input  logic                  pop_i,
    output logic                  free_o,
    output logic                  valid_o,
    output logic [D_WIDTH-1:0]    data_o
);

    localparam int             BW     = $clog2(BN);
    localparam logic [BW-1:0]  B_LAST = BW'(BN - 1);

    logic [D_WIDTH-1:0] slot_q [2][BN];
    logic [1:0]         full_q, full_d;
    logic               act_q, act_d;
    logic               wr_q, wr_d;
    logic               pend_q, pend_slot_q;
    logic [BW-1:0]      b_q, b_d;
    logic               finish, wr_busy;

    assign valid_o = full_q[act_q];
    assign finish  = pop_i && valid_o && (b_q == B_LAST);
    // A read issued now lands two edges later, so a slot draining this cycle counts as free.
    assign wr_busy = full_q[wr_q] || (pend_q && (pend_slot_q == wr_q));
    assign free_o  = !wr_busy || (finish && (act_q == wr_q));
    assign data_o  = valid_o ? slot_q[act_q][b_q] : '0;

    always_comb begin
        full_d = full_q;
        act_d  = act_q;
        wr_d   = wr_q;
        b_d    = b_q;
        if (pop_i && valid_o) begin
            if (b_q == B_LAST) begin
                full_d[act_q] = 1'b0;
                act_d         = ~act_q;
                b_d           = '0;
            end else begin
                b_d = b_q + 1'b1;
            end
        end
        if (pend_q) full_d[pend_slot_q] = 1'b1;
        if (issue_i) wr_d = ~wr_q;
        if (clr_i) begin
            full_d = '0;
            act_d  = 1'b0;
            wr_d   = 1'b0;
            b_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q      <= '0;
            act_q       <= 1'b0;
            wr_q        <= 1'b0;
            b_q         <= '0;
            pend_q      <= 1'b0;
            pend_slot_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            act_q       <= act_d;
            wr_q        <= wr_d;
            b_q         <= b_d;
            pend_q      <= issue_i;
            pend_slot_q <= wr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (pend_q) begin
            for (int b = 0; b < BN; b++) begin
                slot_q[pend_slot_q][b] <= rd_data_i[b*D_WIDTH +: D_WIDTH];
            end
        end
    end

endmodule

// File: rtl/mem_unload_streamer.sv
// Reads the banked coefficient memory row by row after DONE and streams the
// words out in natural order, index = k*BN + b.
module mem_unload_streamer
    import nwc_pkg::*;
#(
    parameter int D_WIDTH = nwc_pkg::D_WIDTH,
    parameter int BN      = nwc_pkg::BN,
    parameter int MA      = nwc_pkg::MA,
    parameter int AW      = (MA > 1) ? $clog2(MA) : 1,
    parameter int IW      = $clog2(BN * MA)
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_unload_streamer_if.master io
);

    localparam logic [AW-1:0] K_LAST = AW'(MA - 1);
    localparam logic [IW-1:0] I_LAST = IW'(BN * MA - 1);

    unload_state_e      state_q, state_d;
    logic [AW-1:0]      k_q, k_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               done_q, done_d;
    logic               start_ok, rd_en, slot_free, beat_vld, hs;
    logic [D_WIDTH-1:0] beat_data;

    // A start coinciding with the done pulse is dropped so DONE cannot retrigger.
    assign start_ok = io.start && (state_q == IDLE) && !done_q;
    assign rd_en    = (state_q == RUN) && slot_free;
    assign hs       = beat_vld && io.out_ready;

    row_pingpong_buf #(
        .D_WIDTH (D_WIDTH),
        .BN      (BN)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start_ok),
        .issue_i   (rd_en),
        .rd_data_i (io.mem_rd_data),
        .pop_i     (hs),
        .free_o    (slot_free),
        .valid_o   (beat_vld),
        .data_o    (beat_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (rd_en && (k_q == K_LAST)) state_d = FLUSH;
            FLUSH: begin
                if (hs && (idx_q == I_LAST)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_ok) begin
            k_d   = '0;
            idx_d = '0;
        end
        if (rd_en) begin
            addr_d = k_q;
            if (k_q != K_LAST) k_d = k_q + 1'b1;
        end
        if (hs) idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
    end

    always_comb begin
        io.mem_rd_en   = rd_en;
        io.mem_rd_addr = rd_en ? k_q : addr_q;
        io.out_valid   = beat_vld;
        io.out_data    = beat_data;
        io.out_index   = idx_q;
        io.out_last    = beat_vld && (idx_q == I_LAST);
        io.busy        = (state_q != IDLE);
        io.done        = done_q;
    end

endmodule

// File: tb/tb_mem_unload_streamer.sv
// Directed bench: 16-bank x 64-row streaming build plus a 2-bank x 1-row corner build.
`timescale 1ns/1ps
module tb_mem_unload_streamer;

    localparam int DW = 32;
    localparam int N  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [DW-1:0] mem_arr [16][64];
    logic [DW-1:0] mem2    [2][1];

    always #5 clk = ~clk;

    mem_unload_streamer_if #(.D_WIDTH(DW), .BN(16), .AW(6), .IW(10)) io  ();
    mem_unload_streamer_if #(.D_WIDTH(DW), .BN(2),  .AW(1), .IW(1))  io2 ();

    mem_unload_streamer #(.D_WIDTH(DW), .BN(16), .MA(64)) u_dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    mem_unload_streamer #(.D_WIDTH(DW), .BN(2), .MA(1)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .io  (io2)
    );

    // Banked memory models: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (io.mem_rd_en) begin
            for (int b = 0; b < 16; b++) io.mem_rd_data[b*DW +: DW] <= mem_arr[b][io.mem_rd_addr];
        end
    end

    always @(posedge clk) begin
        if (io2.mem_rd_en) io2.mem_rd_data <= {mem2[1][io2.mem_rd_addr], mem2[0][io2.mem_rd_addr]};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic st, input logic rdy);
        @(posedge clk);
        #1;
        io.start     = st;
        io.out_ready = rdy;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, io.out_valid, 0);
        chk({tag, "_data"},  io.out_data, 0);
        chk({tag, "_index"}, io.out_index, 0);
        chk({tag, "_last"},  io.out_last, 0);
        chk({tag, "_rd_en"}, io.mem_rd_en, 0);
        chk({tag, "_addr"},  io.mem_rd_addr, 0);
        chk({tag, "_busy"},  io.busy, 0);
        chk({tag, "_done"},  io.done, 0);
    endtask

    // mode 0: ready high; 1: random 30% ready; 2: 200-cycle stall on first beat;
    // 3: stray starts at beat 500 and in the done cycle; 4: reset at beat 300.
    task automatic unload(input int mode);
        int            exp_idx = 0, issued = 0, cyc = 0, stall = 0;
        int            first_cyc = -1, last_cyc = -1;
        logic          seen_last = 1'b0, held = 1'b0, rdy, fin;
        logic [DW-1:0] h_data = '0;
        logic [9:0]    h_idx = '0;
        logic          h_last = 1'b0;

        step(1'b1, 1'b1);
        chk("pre_start_busy", io.busy, 0);
        chk("pre_start_done", io.done, 0);
        while (!seen_last && cyc < 6000) begin
            case (mode)
                1:       rdy = ($urandom_range(0, 99) < 30);
                2:       rdy = (stall >= 200);
                default: rdy = 1'b1;
            endcase
            step(mode == 3 && exp_idx == 500, rdy);
            cyc++;
            if (cyc == 1) begin
                chk("issue0_en", io.mem_rd_en, 1);
                chk("issue0_busy", io.busy, 1);
            end
            if (io.mem_rd_en) begin
                fin = io.out_valid && io.out_ready && (exp_idx % 16 == 15);
                chk("rd_addr", io.mem_rd_addr, issued);
                chk("rd_room", (issued - exp_idx / 16 - int'(fin)) <= 1, 1);
                issued++;
            end
            chk("no_early_done", io.done, 0);
            if (held) begin
                chk("hold_valid", io.out_valid, 1);
                chk("hold_data", io.out_data, h_data);
                chk("hold_idx", io.out_index, h_idx);
                chk("hold_last", io.out_last, h_last);
            end
            if (io.out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk("beat_idx", io.out_index, exp_idx);
                chk("beat_data", io.out_data, exp_idx);
                chk("beat_last", io.out_last, exp_idx == N - 1);
                if (mode == 4 && exp_idx == 300) break;
                held   = !io.out_ready;
                h_data = io.out_data;
                h_idx  = io.out_index;
                h_last = io.out_last;
                if (mode == 2 && stall < 200) begin
                    stall++;
                    if (stall == 200) begin
                        chk("stall_reads", issued, 2);
                        chk("stall_idx", io.out_index, 0);
                    end
                end
                if (io.out_ready) begin
                    if (exp_idx == N - 1) begin
                        seen_last = 1'b1;
                        last_cyc  = cyc;
                    end
                    exp_idx++;
                end
            end else begin
                held = 1'b0;
            end
        end

        if (mode == 4) begin
            rst = 1'b0;
            #1;
            chk_quiet("rst_mid");
            @(posedge clk);
            #1;
            rst = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step(1'b0, 1'b1);
                chk("rst_no_done", io.done, 0);
                chk("rst_idle", io.busy, 0);
            end
            return;
        end

        chk("stream_complete", seen_last, 1);
        chk("beat_count", exp_idx, N);
        if (mode == 0) begin
            chk("first_beat_cyc", first_cyc, 3);
            chk("last_beat_cyc", last_cyc, 3 + N - 1);
        end
        step(mode == 3, 1'b1);
        chk("done_pulse", io.done, 1);
        chk("done_busy", io.busy, 0);
        chk("done_no_valid", io.out_valid, 0);
        if (mode != 3) begin
            step(1'b0, 1'b1);
            chk("done_single", io.done, 0);
            chk("stay_idle", io.busy, 0);
        end
    endtask

    task automatic small_build();
        int reads = 0, beats = 0;
        @(posedge clk);
        #1;
        io2.start     = 1'b1;
        io2.out_ready = 1'b1;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            @(posedge clk);
            #1;
            io2.start = 1'b0;
            #1;
            if (io2.mem_rd_en) begin
                reads++;
                chk("s_rd_addr", io2.mem_rd_addr, 0);
            end
            if (io2.out_valid) begin
                chk("s_data", io2.out_data, (beats == 0) ? 5 : 7);
                chk("s_idx", io2.out_index, beats);
                chk("s_last", io2.out_last, beats == 1);
                beats++;
            end
        end
        chk("s_beats", beats, 2);
        @(posedge clk);
        #2;
        chk("s_done", io2.done, 1);
        chk("s_no_rd", io2.mem_rd_en, 0);
        chk("s_reads", reads, 1);
    endtask

    initial begin
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 64; k++) mem_arr[b][k] = DW'(k * 16 + b);
        end
        mem2[0][0]    = 32'd5;
        mem2[1][0]    = 32'd7;
        io.start      = 1'b0;
        io.out_ready  = 1'b0;
        io2.start     = 1'b0;
        io2.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_quiet("rst");
        rst = 1'b1;

        unload(0);
        unload(1);
        unload(2);
        unload(3);
        unload(0);
        unload(4);
        unload(0);
        small_build();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
